// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types, mode encoding and select-width helper for mux_scan
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_scan_next_sel.sv
// mux_scan_next_sel: circular priority finder over a channel mask
// mask: channel participation; start: search origin; incl: 1 = origin itself is a candidate
// idx: first hit; found: any hit; wrapped: hit is at or below the origin (circular wrap)
module mux_scan_next_sel
  import mux_scan_pkg::*;
#(
  parameter int NCH = 4,
  localparam int SW = sel_w(NCH)
)(
  input  logic [NCH-1:0] mask,
  input  logic [SW-1:0]  start,
  input  logic           incl,
  output logic [SW-1:0]  idx,
  output logic           found,
  output logic           wrapped
);
  int base, p;
  always_comb begin
    base = (int'(start) >= NCH) ? 0 : int'(start);
    idx = '0;
    found = 1'b0;
    p = 0;
    for (int k = NCH; k >= 1; k--) begin
      p = base + (incl ? k - 1 : k);
      p = (p >= NCH) ? p - NCH : p;
      if (mask[p]) begin
        idx = SW'(p);
        found = 1'b1;
      end
    end
    wrapped = found && (incl ? idx < start : idx <= start);
  end
endmodule

// File: rtl/mux_scan.sv
// mux_scan: registered channel mux with direct select and masked auto-scan
// clk/rst_n: clock, async active-low reset; d: packed channel data; s: select / scan origin
// mode: 0 direct, 1 scan; en: enable; mask: scan participation
// y/ch/y_valid: registered sample, its channel, validity; wrap: pulse after a wrapping advance
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W = 1,
  parameter int DWELL = 1,
  localparam int SW = sel_w(NCH)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] d,
  input  logic [SW-1:0]    s,
  input  logic             mode,
  input  logic             en,
  input  logic [NCH-1:0]   mask,
  output logic [W-1:0]     y,
  output logic [SW-1:0]    ch,
  output logic             y_valid,
  output logic             wrap
);
  localparam int CW = sel_w(DWELL);
  state_t state, nstate;
  logic live, entry, adv, upd, found, wrapped;
  logic [SW-1:0] ptr, idx, sel;
  logic [CW-1:0] cnt;
  logic [W-1:0] dsel;
  mux_scan_next_sel #(.NCH(NCH)) u_next (
    .mask(mask),
    .start(entry ? s : ptr),
    .incl(entry),
    .idx(idx),
    .found(found),
    .wrapped(wrapped)
  );
  // live marks scan progress worth keeping: an en=0 pause resumes it,
  // while reset or a pass through DIRECT forces a fresh start from s
  always_comb begin
    nstate = !en ? IDLE : (mode == MODE_SCAN) ? SCAN : DIRECT;
    entry = nstate == SCAN && !live;
    adv = nstate == SCAN && live && |mask && (!mask[ptr] || int'(cnt) == DWELL - 1);
    upd = nstate == DIRECT || (nstate == SCAN && (entry ? found : |mask));
    sel = (nstate == DIRECT) ? s : (entry || adv) ? idx : ptr;
    dsel = (int'(sel) < NCH) ? d[int'(sel)*W +: W] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      live <= 1'b0;
      ptr <= '0;
      cnt <= '0;
      y <= '0;
      ch <= '0;
      y_valid <= 1'b0;
      wrap <= 1'b0;
    end else begin
      state <= nstate;
      wrap <= adv && wrapped;
      y_valid <= upd && int'(sel) < NCH;
      if (upd) begin
        y <= dsel;
        ch <= sel;
      end
      if (nstate == DIRECT) live <= 1'b0;
      if (nstate == SCAN) begin
        live <= 1'b1;
        cnt <= (entry || adv) ? '0 : (|mask) ? cnt + 1'b1 : cnt;
        if ((entry || adv) && found) ptr <= idx;
      end
    end
  end
endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: directed and random checks of mux_scan against a behavioural model
module tb_mux_scan;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] d;
  logic [1:0] s;
  logic mode, en;
  logic [3:0] mask;
  logic [7:0] oy [3];
  logic [1:0] och [3];
  logic ov [3];
  logic ow [3];
  int nassert = 0;
  int nfail = 0;
  int nch [3] = '{4, 4, 3};
  int dwl [3] = '{2, 4, 1};
  int m_y [3], m_ch [3], m_v [3], m_w [3], m_ptr [3], m_cnt [3], m_live [3];
  int e33 [4] = '{0, 0, 1, 0};
  int e34c [8] = '{0, 0, 1, 1, 3, 3, 0, 0};
  int e34y [8] = '{'h11, 'h11, 'h22, 'h22, 'h44, 'h44, 'h11, 'h11};
  int e34w [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int e38 [4] = '{0, 1, 2, 0};

  always #5 clk = ~clk;

  mux_scan #(.NCH(4), .W(8), .DWELL(2)) u_a (
    .clk(clk), .rst_n(rst_n), .d(d), .s(s), .mode(mode), .en(en), .mask(mask),
    .y(oy[0]), .ch(och[0]), .y_valid(ov[0]), .wrap(ow[0]));
  mux_scan #(.NCH(4), .W(8), .DWELL(4)) u_b (
    .clk(clk), .rst_n(rst_n), .d(d), .s(s), .mode(mode), .en(en), .mask(mask),
    .y(oy[1]), .ch(och[1]), .y_valid(ov[1]), .wrap(ow[1]));
  mux_scan #(.NCH(3), .W(8), .DWELL(1)) u_c (
    .clk(clk), .rst_n(rst_n), .d(d[23:0]), .s(s), .mode(mode), .en(en), .mask(mask[2:0]),
    .y(oy[2]), .ch(och[2]), .y_valid(ov[2]), .wrap(ow[2]));

  function automatic int nxt(int mk, int st, bit incl, int n);
    for (int k = incl ? 0 : 1; k <= (incl ? n - 1 : n); k++)
      if (mk[(st + k) % n]) return (st + k) % n;
    return -1;
  endfunction

  function automatic int chan(int c);
    return int'((d >> (8 * c)) & 32'hff);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_y[i] = 0; m_ch[i] = 0; m_v[i] = 0; m_w[i] = 0;
      m_ptr[i] = 0; m_cnt[i] = 0; m_live[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int n, mk, p, sv;
      n = nch[i];
      sv = int'(s);
      mk = int'(mask) & ((1 << n) - 1);
      m_w[i] = 0;
      if (!en) m_v[i] = 0;
      else if (!mode) begin
        m_live[i] = 0;
        m_ch[i] = sv;
        m_v[i] = (sv < n) ? 1 : 0;
        m_y[i] = (sv < n) ? chan(sv) : 0;
      end else if (m_live[i] == 0) begin
        m_live[i] = 1;
        m_cnt[i] = 0;
        p = nxt(mk, sv, 1, n);
        m_v[i] = (p >= 0) ? 1 : 0;
        if (p >= 0) begin
          m_ptr[i] = p; m_ch[i] = p; m_y[i] = chan(p);
        end
      end else if (mk == 0) m_v[i] = 0;
      else begin
        if (!mk[m_ptr[i]] || m_cnt[i] == dwl[i] - 1) begin
          p = nxt(mk, m_ptr[i], 0, n);
          m_w[i] = (p <= m_ptr[i]) ? 1 : 0;
          m_ptr[i] = p;
          m_cnt[i] = 0;
        end else m_cnt[i]++;
        m_ch[i] = m_ptr[i];
        m_y[i] = chan(m_ptr[i]);
        m_v[i] = 1;
      end
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check();
    for (int i = 0; i < 3; i++) begin
      cmp($sformatf("y%0d", i), 32'(oy[i]), m_y[i]);
      cmp($sformatf("ch%0d", i), 32'(och[i]), m_ch[i]);
      cmp($sformatf("valid%0d", i), 32'(ov[i]), m_v[i]);
      cmp($sformatf("wrap%0d", i), 32'(ow[i]), m_w[i]);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (rst_n) model_step();
      #1 check();
    end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 1'b0; s = '0; mask = '0; d = '0;
    #1 rst_n = 1'b0;
    model_reset();
    step(2);
    rst_n = 1'b1;
    // direct select, one cycle latency
    en = 1'b1; mode = 1'b0; d = 32'h0001_0000;
    for (int k = 0; k < 4; k++) begin
      s = 2'(k);
      step();
      cmp("r33_y", 32'(oy[0]), e33[k]);
      cmp("r33_valid", 32'(ov[0]), 1);
    end
    cmp("r38_direct_y", 32'(oy[2]), 0);
    cmp("r38_direct_valid", 32'(ov[2]), 0);
    // scan with DWELL=2 over mask 1011
    mode = 1'b1; mask = 4'b1011; s = 2'd0; d = 32'h4433_2211;
    for (int k = 0; k < 8; k++) begin
      step();
      cmp("r34_ch", 32'(och[0]), e34c[k]);
      cmp("r34_y", 32'(oy[0]), e34y[k]);
      cmp("r34_wrap", 32'(ow[0]), e34w[k]);
    end
    // mask edit mid-dwell on DWELL=4 instance
    mode = 1'b0; step();
    mode = 1'b1; s = 2'd1; step();
    cmp("r35_start", 32'(och[1]), 1);
    mask = 4'b1001; step();
    cmp("r35_jump", 32'(och[1]), 3);
    step(3);
    cmp("r35_restart", 32'(och[1]), 3);
    step();
    // empty mask
    mask = 4'b0000; step(3);
    cmp("r36_valid", 32'(ov[0]), 0);
    cmp("r36_wrap", 32'(ow[0]), 0);
    mask = 4'b0100; step(2);
    cmp("r36_ch", 32'(och[0]), 2);
    cmp("r36_valid2", 32'(ov[0]), 1);
    // enable pause and async reset
    mode = 1'b0; step();
    mode = 1'b1; mask = 4'b1011; s = 2'd0; step(2);
    en = 1'b0; step(3);
    cmp("r37_freeze", 32'(och[1]), 0);
    en = 1'b1; step(2);
    cmp("r37_hold", 32'(och[1]), 0);
    step();
    cmp("r37_resume", 32'(och[1]), 1);
    rst_n = 1'b0;
    #1 model_reset();
    cmp("r37_rst_y", 32'(oy[0]), 0);
    cmp("r37_rst_ch", 32'(och[1]), 0);
    cmp("r37_rst_valid", 32'(ov[0]), 0);
    check();
    step(2);
    rst_n = 1'b1;
    // three-channel instance
    mode = 1'b0; s = 2'd3; step();
    cmp("r38_s3_valid", 32'(ov[2]), 0);
    cmp("r38_s3_y", 32'(oy[2]), 0);
    mode = 1'b1; mask = 4'b0111; s = 2'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      cmp("r38_ch", 32'(och[2]), e38[k]);
    end
    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      d = $urandom;
      s = 2'($urandom);
      if ($urandom_range(0, 3) == 0) mask = 4'($urandom);
      en = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1 model_reset();
        check();
      end else rst_n = 1'b1;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter NCH, default 4, number of input channels (2..32).
REQ-002 Parameter W, default 1, data width per channel in bits (1..32).
REQ-003 Parameter DWELL, default 1, cycles spent on each channel in scan mode (1..255).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 d  input  NCH*W  packed channel data; channel i occupies bits [i*W +: W].
REQ-007 s  input  SW=max(1,clog2(NCH))  channel select for direct mode and scan start point.
REQ-008 mode  input  1  0 = direct select, 1 = auto-scan.
REQ-009 en  input  1  block enable.
REQ-010 mask  input  NCH  scan participation, one bit per channel; 1 = included.
REQ-011 y  output  W  registered selected data.
REQ-012 ch  output  SW  index of the channel currently driving y.
REQ-013 y_valid  output  1  y/ch hold a valid sample this cycle.
REQ-014 wrap  output  1  one-cycle pulse when the scan pointer wraps.

Function
REQ-015 FSM states are IDLE, DIRECT and SCAN: IDLE when en=0; otherwise DIRECT when mode=0 and SCAN when mode=1; transitions are evaluated every cycle.
REQ-016 DIRECT: y <= d[s], ch <= s, y_valid <= 1, with one-cycle latency from s/d to y.
REQ-017 DIRECT with s >= NCH (non-power-of-two NCH): y <= 0, ch <= s, y_valid <= 0.
REQ-018 IDLE: y and ch hold their values, y_valid <= 0, wrap <= 0, dwell counter and pointer frozen.
REQ-019 Entry into SCAN from IDLE or DIRECT: pointer loads the first masked channel at or above s, searching circularly; dwell counter clears to 0; wrap does not pulse.
REQ-020 SCAN, every cycle: y <= d[ptr], ch <= ptr, y_valid <= mask[ptr].
REQ-021 Dwell counter counts 0..DWELL-1; at DWELL-1 the pointer advances to the next masked channel strictly after ptr, searching circularly, and the counter returns to 0.
REQ-022 wrap pulses high in the cycle after an advance whose new pointer <= old pointer; with a single masked channel it therefore pulses once every DWELL cycles.
REQ-023 If mask[ptr] clears mid-dwell, the pointer advances on the next edge regardless of the counter, and the counter clears.
REQ-024 mask all-zero in SCAN: pointer and counter hold, y holds, y_valid <= 0, wrap <= 0; scanning resumes per REQ-023 once any mask bit sets.
REQ-025 A mode change from SCAN to DIRECT takes effect on the next edge; scan state is discarded.
REQ-026 Inputs d, s and mask are sampled only at clock edges; no combinational path from any input to any output.

Reset
REQ-027 rst_n low asynchronously forces y=0, ch=0, y_valid=0, wrap=0, pointer=0, dwell counter=0 and state IDLE.
REQ-028 Reset asserted mid-dwell or mid-advance discards all scan progress; after release, behaviour is identical to first power-up.
REQ-029 Reset release is synchronised to clk by the system; the block itself contains no reset synchroniser.

Structure
REQ-030 Shared package mux_scan_pkg holds the state enum (IDLE/DIRECT/SCAN), the mode encoding constants and the select-width function.
REQ-031 Sub-module mux_scan_next_sel is a combinational circular priority finder: inputs mask, start index and an inclusive/exclusive flag; outputs next index, a found flag and a wrapped flag.
REQ-032 mux_scan instantiates mux_scan_next_sel once; no other sub-modules are used.

Verification
REQ-033 Direct mode (NCH=4, W=1): with d=4'b0100 and s stepping 0,1,2,3 one per cycle, y is 0,0,1,0 one cycle later each, and y_valid stays 1.
REQ-034 Scan mode (NCH=4, W=8, DWELL=2, mask=4'b1011, s=0, d={8'h44,8'h33,8'h22,8'h11}): ch runs 0,0,1,1,3,3,0,0, y tracks 11,11,22,22,44,44,11,11, and wrap pulses once after each 3->0 advance.
REQ-035 Mask edit: in scan on ch=1 at counter 0 with DWELL=4, clearing mask[1] moves ch to 3 on the next edge and the counter restarts.
REQ-036 Empty mask: with mask=0 in scan, y_valid=0, ch holds and wrap stays 0; setting mask=4'b0100 gives ch=2 and y_valid=1 within 2 cycles.
REQ-037 Enable and reset: dropping en for 3 cycles mid-dwell freezes ch and the counter, and they resume on en=1; asserting rst_n=0 mid-scan immediately gives y=0, ch=0, y_valid=0.
REQ-038 Non-power-of-two NCH=3: direct mode with s=3 gives y=0 and y_valid=0; scan with mask=3'b111 cycles ch 0,1,2,0 and never reaches 3.
